// File: rtl/parking_lot_ctrl.sv
// Parking lot controller: occupancy bitmap, lowest-free slot allocation, timed entry door
// with a one-deep pending-entry buffer, and entry-reject / illegal-exit pulses.
module parking_lot_ctrl #(
  parameter int unsigned NUM_SLOTS = 4,
  parameter int unsigned SLOT_W    = 2,
  parameter int unsigned DOOR_HOLD = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 entry_sensor,
  input  logic                 exit_sensor,
  input  logic [SLOT_W-1:0]    exit_location,
  output logic                 door_open,
  output logic                 full_light,
  output logic [NUM_SLOTS-1:0] occupancy,
  output logic [SLOT_W:0]      free_count,
  output logic [SLOT_W-1:0]    best_slot,
  output logic                 entry_rejected,
  output logic                 exit_error
);

  localparam int unsigned CntW = $clog2(DOOR_HOLD + 1);

  typedef enum logic [0:0] {StIdle, StOpen} state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [NUM_SLOTS-1:0]   occ_q, occ_d;
  logic                   door_q, door_d;
  logic                   pending_q, pending_d;
  logic                   rej_q, rej_d;
  logic                   err_q, err_d;
  logic                   entry_q;

  logic                   entry_ev;
  logic [NUM_SLOTS-1:0]   exit_hit;
  logic                   exit_legal;
  logic [NUM_SLOTS-1:0]   occ_x;
  logic [NUM_SLOTS-1:0]   alloc;
  logic                   full_x;
  logic                   req;

  assign entry_ev = entry_sensor & ~entry_q;

  // Exit decode; an index beyond NUM_SLOTS matches no slot and is therefore illegal.
  always_comb begin
    exit_hit = '0;
    for (int i = 0; i < int'(NUM_SLOTS); i++) begin
      exit_hit[i] = exit_sensor && (exit_location == SLOT_W'(i));
    end
    exit_legal = |(exit_hit & occ_q);
    occ_x      = exit_legal ? (occ_q & ~exit_hit) : occ_q;
    full_x     = &occ_x;
  end

  // Lowest free slot of the post-exit bitmap, as a one-hot grant.
  always_comb begin
    alloc = '0;
    for (int i = int'(NUM_SLOTS) - 1; i >= 0; i--) begin
      if (!occ_x[i]) begin
        alloc    = '0;
        alloc[i] = 1'b1;
      end
    end
  end

  // State register: FSM state and door hold counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Datapath registers: bitmap, door, pending buffer, pulses, sensor history.
  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q     <= '0;
      door_q    <= 1'b0;
      pending_q <= 1'b0;
      rej_q     <= 1'b0;
      err_q     <= 1'b0;
      entry_q   <= 1'b0;
    end else begin
      occ_q     <= occ_d;
      door_q    <= door_d;
      pending_q <= pending_d;
      rej_q     <= rej_d;
      err_q     <= err_d;
      entry_q   <= entry_sensor;
    end
  end

  // Next-state logic: admission in IDLE, door timing and entry buffering in OPEN.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    occ_d     = occ_x;
    door_d    = door_q;
    pending_d = pending_q;
    rej_d     = 1'b0;
    err_d     = exit_sensor & ~exit_legal;
    req       = entry_ev | pending_q;

    unique case (state_q)
      StIdle: begin
        if (req) begin
          pending_d = 1'b0;
          if (!full_x) begin
            occ_d   = occ_x | alloc;
            door_d  = 1'b1;
            cnt_d   = CntW'(DOOR_HOLD - 1);
            state_d = StOpen;
          end else begin
            rej_d = 1'b1;
          end
        end
      end
      StOpen: begin
        if (cnt_q == '0) begin
          door_d  = 1'b0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
        // Only one car can wait behind the door; a further arrival is turned away.
        if (entry_ev) begin
          if (!pending_q) pending_d = 1'b1;
          else            rej_d     = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs: registered controls plus status derived directly from the bitmap.
  always_comb begin
    door_open      = door_q;
    occupancy      = occ_q;
    entry_rejected = rej_q;
    exit_error     = err_q;
    full_light     = &occ_q;
    free_count     = (SLOT_W + 1)'(NUM_SLOTS);
    best_slot      = '0;
    for (int i = 0; i < int'(NUM_SLOTS); i++) begin
      free_count = free_count - (SLOT_W + 1)'(occ_q[i]);
    end
    for (int i = int'(NUM_SLOTS) - 1; i >= 0; i--) begin
      if (!occ_q[i]) best_slot = SLOT_W'(i);
    end
  end

endmodule
